cu_multicycle_fsm: RTL and testbench

Main sequencing controller for the multicycle ARM-subset core. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU, memory port, IR and PC enables. It sits beside the existing main/ALU decoder and condition logic, replacing the single-cycle control path. The memory port uses a req/ready handshake with a bounded wait timeout.

---
 rtl/cu_pkg.sv | 36 +++
 rtl/cu_wait_timer.sv | 29 ++
 rtl/cu_multicycle_fsm.sv | 142 ++++++++++++++
 tb/tb_cu_multicycle_fsm.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
package cu_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] FUNCT_CMP = 4'b1010;

    // States that hold mem_req high and may stall on mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Counts stalled memory cycles and flags a timeout on the last allowed one.
module cu_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    input  logic clear,
    output logic timeout
);

    logic [CNT_W-1:0] cnt;

    assign timeout = active && !mem_ready && (cnt == CNT_W'(WAIT_MAX - 1));

    // Timeout clears too, so a refetch from FETCH starts a fresh window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || timeout) begin
            cnt <= '0;
        end else if (active && !mem_ready) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cu_multicycle_fsm.sv
// Multicycle sequencing controller: fetch/decode/execute/memory/writeback.
// Memory handshake: mem_req is held until a cycle with mem_ready=1 completes the access.
module cu_multicycle_fsm
    import cu_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic       cond_ex,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_w,
    output logic       adr_src,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op,
    output logic [1:0] result_src,
    output logic       reg_w,
    output logic       pc_write,
    output logic       bus_err,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state, state_n;
    logic   timeout;
    logic   rd_pc;

    assign rd_pc = (rd == 4'b1111);

    cu_wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .active   (is_wait_state(state)),
        .mem_ready(mem_ready),
        .clear    (state_n != state),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            FETCH:  if (mem_ready) state_n = DECODE;
            DECODE: begin
                if (!cond_ex) state_n = FETCH;
                else begin
                    case (op)
                        OP_MEM:  state_n = MEMADR;
                        OP_DP:   state_n = funct[5] ? EXECI : EXECR;
                        OP_BR:   state_n = BRANCH;
                        default: state_n = FETCH;
                    endcase
                end
            end
            MEMADR: state_n = funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_n = MEMWB;
                    else if (timeout) state_n = FETCH;
            MEMWR:  if (mem_ready || timeout) state_n = FETCH;
            EXECR, EXECI: state_n = (funct[4:1] == FUNCT_CMP) ? FETCH : ALUWB;
            default: state_n = FETCH;
        endcase
    end

    // Everything forced low during reset so downstream enables stay quiet.
    always_comb begin
        mem_req    = 1'b0;
        mem_w      = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = 1'b0;
        result_src = RES_ALUOUT;
        reg_w      = 1'b0;
        pc_write   = 1'b0;
        bus_err    = 1'b0;
        illegal_op = 1'b0;
        state_o    = 4'(FETCH);
        if (reset) begin
            state_o = 4'(state);
            bus_err = timeout;
            case (state)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                DECODE: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    illegal_op = (op == 2'b11);
                end
                MEMADR: alu_src_b = SRCB_IMM;
                MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                MEMWR: begin
                    mem_req = 1'b1;
                    mem_w   = 1'b1;
                    adr_src = 1'b1;
                end
                MEMWB: begin
                    result_src = RES_DATA;
                    reg_w      = 1'b1;
                    pc_write   = rd_pc;
                end
                EXECR: alu_op = 1'b1;
                EXECI: begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = 1'b1;
                end
                ALUWB: begin
                    reg_w    = 1'b1;
                    pc_write = rd_pc;
                end
                BRANCH: begin
                    alu_src_b  = SRCB_IMM;
                    result_src = RES_ALU;
                    pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_multicycle_fsm.sv
// Directed cycle-by-cycle bench for cu_multicycle_fsm with an expected-output queue.
module tb_cu_multicycle_fsm;

    localparam int W = 18;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;
    logic [3:0] rd = '0;
    logic       cond_ex = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_w, adr_src, ir_write, alu_src_a, alu_op;
    logic       reg_w, pc_write, bus_err, illegal_op;
    logic [1:0] alu_src_b, result_src;
    logic [3:0] state_o;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    cu_multicycle_fsm #(.WAIT_MAX(15), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
        .cond_ex(cond_ex), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_w(mem_w), .adr_src(adr_src), .ir_write(ir_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .reg_w(reg_w), .pc_write(pc_write),
        .bus_err(bus_err), .illegal_op(illegal_op), .state_o(state_o)
    );

    // clock
    always #5 clk = ~clk;

    // {state, mem_req, mem_w, adr_src, ir_write, src_a, src_b, alu_op, res, reg_w, pc_write, bus_err, illegal}
    function automatic logic [W-1:0] ev(input int st, input logic rdy, input logic pcw,
                                        input logic err, input logic ill);
        logic req, w, adr, irw, a, aop, rw, pc;
        logic [1:0] b, res;
        req = 0; w = 0; adr = 0; irw = 0; a = 0; aop = 0; rw = 0; pc = 0;
        b = 2'b00; res = 2'b00;
        case (st)
            0: begin req = 1; a = 1; b = 2'b10; res = 2'b10; irw = rdy; pc = rdy; end
            1: begin a = 1; b = 2'b10; res = 2'b10; end
            2: b = 2'b01;
            3: begin req = 1; adr = 1; end
            4: begin res = 2'b01; rw = 1; pc = pcw; end
            5: begin req = 1; w = 1; adr = 1; end
            6: aop = 1;
            7: begin b = 2'b01; aop = 1; end
            8: begin rw = 1; pc = pcw; end
            9: begin b = 2'b01; res = 2'b10; pc = 1; end
            default: ;
        endcase
        return {4'(st), req, w, adr, irw, a, b, aop, res, rw, pc, err, ill};
    endfunction

    // driver: apply mem_ready, queue expectation, compare, advance one cycle
    task automatic step(input string tag, input logic rdy, input logic [W-1:0] e);
        logic [W-1:0] got, want;
        mem_ready = rdy;
        exp_q.push_back(e);
        #1;
        got = {state_o, mem_req, mem_w, adr_src, ir_write, alu_src_a, alu_src_b,
               alu_op, result_src, reg_w, pc_write, bus_err, illegal_op};
        want = exp_q.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
        @(negedge clk);
    endtask

    task automatic instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                         input logic c);
        op = o; funct = f; rd = r; cond_ex = c;
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b0;
        step("rst0", 1'b0, '0);
        step("rst1", 1'b1, '0);
        reset = 1'b1;

        // ADD register, rd=3
        instr(2'b00, 6'b001000, 4'b0011, 1'b1);
        step("add_fetch", 1'b1, ev(0, 1, 0, 0, 0));
        step("add_dec",   1'b1, ev(1, 0, 0, 0, 0));
        step("add_exr",   1'b1, ev(6, 0, 0, 0, 0));
        step("add_wb",    1'b1, ev(8, 0, 0, 0, 0));

        // ADD immediate to PC
        instr(2'b00, 6'b101000, 4'b1111, 1'b1);
        step("addi_fetch", 1'b1, ev(0, 1, 0, 0, 0));
        step("addi_dec",   1'b1, ev(1, 0, 0, 0, 0));
        step("addi_exi",   1'b1, ev(7, 0, 0, 0, 0));
        step("addi_wb",    1'b1, ev(8, 0, 1, 0, 0));

        // LDR to PC with two stall cycles
        instr(2'b01, 6'b011001, 4'b1111, 1'b1);
        step("ldr_fetch", 1'b1, ev(0, 1, 0, 0, 0));
        step("ldr_dec",   1'b1, ev(1, 0, 0, 0, 0));
        step("ldr_adr",   1'b1, ev(2, 0, 0, 0, 0));
        step("ldr_rd0",   1'b0, ev(3, 0, 0, 0, 0));
        step("ldr_rd1",   1'b0, ev(3, 0, 0, 0, 0));
        step("ldr_rd2",   1'b1, ev(3, 1, 0, 0, 0));
        step("ldr_wb",    1'b1, ev(4, 0, 1, 0, 0));

        // LDR interrupted by reset while stalled in MEMRD
        instr(2'b01, 6'b011001, 4'b0100, 1'b1);
        step("ldr2_fetch", 1'b1, ev(0, 1, 0, 0, 0));
        step("ldr2_dec",   1'b1, ev(1, 0, 0, 0, 0));
        step("ldr2_adr",   1'b1, ev(2, 0, 0, 0, 0));
        step("ldr2_rd",    1'b0, ev(3, 0, 0, 0, 0));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step("mid_rst", 1'b1, '0);
        reset = 1'b1;
        step("post_rst", 1'b0, ev(0, 0, 0, 0, 0));

        // CMP: no writeback
        instr(2'b00, 6'b010101, 4'b0000, 1'b1);
        step("cmp_fetch", 1'b1, ev(0, 1, 0, 0, 0));
        step("cmp_dec",   1'b1, ev(1, 0, 0, 0, 0));
        step("cmp_exr",   1'b1, ev(6, 0, 0, 0, 0));

        // B squashed by condition
        instr(2'b10, 6'b000000, 4'b0000, 1'b0);
        step("bsq_fetch", 1'b1, ev(0, 1, 0, 0, 0));
        step("bsq_dec",   1'b1, ev(1, 0, 0, 0, 0));

        // B taken
        instr(2'b10, 6'b000000, 4'b0000, 1'b1);
        step("b_fetch", 1'b1, ev(0, 1, 0, 0, 0));
        step("b_dec",   1'b1, ev(1, 0, 0, 0, 0));
        step("b_br",    1'b1, ev(9, 0, 0, 0, 0));

        // STR with memory never ready: timeout on the 15th cycle
        instr(2'b01, 6'b011000, 4'b0010, 1'b1);
        step("str_fetch", 1'b1, ev(0, 1, 0, 0, 0));
        step("str_dec",   1'b1, ev(1, 0, 0, 0, 0));
        step("str_adr",   1'b1, ev(2, 0, 0, 0, 0));
        for (int i = 0; i < 14; i++) step("str_wait", 1'b0, ev(5, 0, 0, 0, 0));
        step("str_tmo",   1'b0, ev(5, 0, 0, 1, 0));
        step("str_refetch", 1'b0, ev(0, 0, 0, 0, 0));

        // Fetch stall: ready arrives on the last allowed cycle and wins
        for (int i = 0; i < 13; i++) step("fetch_wait", 1'b0, ev(0, 0, 0, 0, 0));
        instr(2'b11, 6'b000000, 4'b0000, 1'b1);
        step("fetch_edge", 1'b1, ev(0, 1, 0, 0, 0));
        step("ill_dec",    1'b1, ev(1, 0, 0, 0, 1));

        // Fetch timeout itself: stays in FETCH, no PC write
        for (int i = 0; i < 14; i++) step("ftmo_wait", 1'b0, ev(0, 0, 0, 0, 0));
        step("ftmo_err",   1'b0, ev(0, 0, 0, 1, 0));
        step("ftmo_after", 1'b0, ev(0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
